// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
// Bit-serial subtractor sequencer. Computes a - b one bit per clock, LSB first,
// using an external one-bit subtractor cell. The operands are captured when a
// start is accepted. Each bit's difference and borrow are collected from the
// cell until the MSB is done. The difference and final borrow are then held
// until the next accepted start.
//
// Ports
//   clk        in   clock; every state update happens on its rising edge
//   rst_n      in   asynchronous reset, active low
//   start      in   begin one subtraction; only seen in IDLE
//   abort      in   cancel a subtraction; only seen in RUN
//   a, b       in   minuend / subtrahend [WIDTH-1:0]
//   cell_a     out  minuend bit to the cell
//   cell_b     out  subtrahend bit to the cell
//   cell_bin   out  borrow-in to the cell
//   cell_d     in   difference bit from the cell
//   cell_bout  in   borrow-out from the cell
//   busy       out  high while bits are being sequenced
//   done       out  one-cycle pulse; d/bout are valid
//   d          out  registered difference [WIDTH-1:0]
//   bout       out  registered final borrow (1 means a < b, unsigned)
//
// state  | meaning
// IDLE   | waiting for start; results held
// RUN    | one operand bit per cycle through the cell
// DONE   | done pulse for one cycle, then back to IDLE
// -----------------------------------------------------------------------------
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             cell_a,
   output logic             cell_b,
   output logic             cell_bin,
   input  logic             cell_d,
   input  logic             cell_bout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_borrow;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_d;
   logic             r_bout;
   logic             r_busy;
   logic             r_done;

   logic             w_run;

   assign w_run    = (r_state == S_RUN);

   // Outside RUN the cell inputs are parked at 0.
   assign cell_a   = w_run ? r_a[r_cnt] : 1'b0;
   assign cell_b   = w_run ? r_b[r_cnt] : 1'b0;
   assign cell_bin = w_run ? r_borrow   : 1'b0;

   assign busy     = r_busy;
   assign done     = r_done;
   assign d        = r_d;
   assign bout     = r_bout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_d      <= '0;
         r_bout   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               // abort has no meaning here, so start wins when both are high.
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
                  r_d      <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_RUN;
               end
            end

            S_RUN: begin
               if (abort) begin
                  r_d      <= '0;
                  r_bout   <= 1'b0;
                  r_cnt    <= '0;
                  r_borrow <= 1'b0;
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end else begin
                  r_d[r_cnt] <= cell_d;
                  r_borrow   <= cell_bout;
                  if (r_cnt == LAST) begin
                     // The counter stops at the MSB so it never runs past WIDTH-1.
                     r_bout  <= cell_bout;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

   logic       clk;
   logic       rst_n;

   logic       start;
   logic       abort;
   logic [7:0] a;
   logic [7:0] b;
   logic       c_a, c_b, c_bin, c_d, c_bout;
   logic       busy, done;
   logic [7:0] d;
   logic       bout;

   logic       start1;
   logic       abort1;
   logic [0:0] a1, b1;
   logic       c1_a, c1_b, c1_bin, c1_d, c1_bout;
   logic       busy1, done1;
   logic [0:0] d1;
   logic       bout1;

   int n_vec;
   int n_err;

   // Reference one-bit full subtractor cells.
   assign c_d     = c_a ^ c_b ^ c_bin;
   assign c_bout  = (~c_a & c_b) | (~(c_a ^ c_b) & c_bin);
   assign c1_d    = c1_a ^ c1_b ^ c1_bin;
   assign c1_bout = (~c1_a & c1_b) | (~(c1_a ^ c1_b) & c1_bin);

   serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a), .b(b),
      .cell_a(c_a), .cell_b(c_b), .cell_bin(c_bin), .cell_d(c_d), .cell_bout(c_bout),
      .busy(busy), .done(done), .d(d), .bout(bout)
   );

   serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .a(a1), .b(b1),
      .cell_a(c1_a), .cell_b(c1_b), .cell_bin(c1_bin), .cell_d(c1_d), .cell_bout(c1_bout),
      .busy(busy1), .done(done1), .d(d1), .bout(bout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 operation. Optionally re-pulses start with other operands
   // at RUN cycle 'repulse' to show it is ignored.
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] exp_d, input logic exp_bo,
                       input int repulse, input string tag);
      int  busy_n;
      int  lat;
      int  done_n;
      bit  got;
      @(negedge clk);
      chk({tag, "_pre_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_pre_busy"}, {31'd0, busy}, 32'd0);
      a = ia; b = ib; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 8'h00; b = 8'hFF;
      busy_n = 0; lat = 0; done_n = 0; got = 0;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         if (i == repulse) begin
            start = 1'b1; a = 8'hFF; b = 8'h00;
         end else if (i == repulse + 1) begin
            start = 1'b0; a = 8'h00; b = 8'hFF;
         end
         if (busy) busy_n++;
         if (done) begin
            got = 1; lat = i; done_n++;
         end
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
      chk({tag, "_busy_cycles"}, busy_n, 32'd8);
      chk({tag, "_latency"}, lat, 32'd9);
      chk({tag, "_d"}, {24'd0, d}, {24'd0, exp_d});
      chk({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_bo});
      chk({tag, "_cell_idle"}, {29'd0, c_a, c_b, c_bin}, 32'd0);
   endtask

   initial begin
      int n;
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
      start1 = 1'b0; abort1 = 1'b0; a1 = '0; b1 = '0;
      #23;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_d", {24'd0, d}, 32'd0);
      chk("rst_bout", {31'd0, bout}, 32'd0);
      chk("rst_cell", {29'd0, c_a, c_b, c_bin}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Basic op with a start re-pulse during RUN, then back-to-back ops.
      run8(8'h5A, 8'h3C, 8'h1E, 1'b0, 3, "op5a3c");
      run8(8'h00, 8'h01, 8'hFF, 1'b1, 0, "op0001");
      run8(8'hA5, 8'hA5, 8'h00, 1'b0, 0, "opa5a5");
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("single_done", n, 32'd0);
      chk("hold_d", {24'd0, d}, 32'd0);

      // Reset at RUN cycle 4, asserted between clock edges.
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_done", {31'd0, done}, 32'd0);
      chk("rst_mid_d", {24'd0, d}, 32'd0);
      chk("rst_mid_bout", {31'd0, bout}, 32'd0);
      chk("rst_mid_cell", {29'd0, c_a, c_b, c_bin}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("rst_mid_no_done", n, 32'd0);
      run8(8'h10, 8'h01, 8'h0F, 1'b0, 0, "op1001");

      // Abort at RUN cycle 3 after an op that leaves bout=1.
      run8(8'h00, 8'h01, 8'hFF, 1'b1, 0, "op0001b");
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_d", {24'd0, d}, 32'd0);
      chk("abort_bout", {31'd0, bout}, 32'd0);
      chk("abort_cell", {29'd0, c_a, c_b, c_bin}, 32'd0);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) n++;
         @(negedge clk);
      end
      chk("abort_no_done", n, 32'd0);

      // abort and start together in IDLE: start is accepted.
      @(negedge clk);
      a = 8'h10; b = 8'h01; start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("idle_abort_start_busy", {31'd0, busy}, 32'd1);
      n = 0;
      for (int i = 0; i < 20 && n == 0; i++) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("idle_abort_start_done", n, 32'd1);
      chk("idle_abort_start_d", {24'd0, d}, 32'h0F);

      // WIDTH=1: 0 - 1 -> d=1, bout=1 after a single RUN cycle.
      @(negedge clk);
      a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
      @(negedge clk);
      chk("w1_busy", {30'd0, busy1, done1}, 32'd2);
      @(negedge clk);
      chk("w1_done", {30'd0, busy1, done1}, 32'd1);
      chk("w1_d", {31'd0, d1}, 32'd1);
      chk("w1_bout", {31'd0, bout1}, 32'd1);
      @(negedge clk);
      chk("w1_done_clear", {30'd0, busy1, done1}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand bit count; legal range 1..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin one subtraction a - b.
REQ-005 SHALL have port abort, input, 1, synchronous cancel of a subtraction in progress.
REQ-006 SHALL have port a, input, WIDTH, minuend, sampled on accepted start.
REQ-007 SHALL have port b, input, WIDTH, subtrahend, sampled on accepted start.
REQ-008 SHALL have port cell_a, output, 1, minuend bit driven to the external one-bit subtractor cell.
REQ-009 SHALL have port cell_b, output, 1, subtrahend bit driven to the cell.
REQ-010 SHALL have port cell_bin, output, 1, borrow-in driven to the cell.
REQ-011 SHALL have port cell_d, input, 1, difference bit returned by the cell (combinational from cell_a/cell_b/cell_bin).
REQ-012 SHALL have port cell_bout, input, 1, borrow-out returned by the cell.
REQ-013 SHALL have port busy, output, 1, high while a subtraction is sequencing.
REQ-014 SHALL have port done, output, 1, one-cycle pulse marking d and bout valid.
REQ-015 SHALL have port d, output, WIDTH, registered difference result.
REQ-016 SHALL have port bout, output, 1, registered final borrow; 1 means a < b unsigned.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-018 IDLE: start=1 SHALL latch a and b into internal registers, clear borrow register to 0, clear bit counter to 0, clear d to 0, and go to RUN next cycle.
REQ-019 RUN: cell_a SHALL equal a_reg[cnt], cell_b SHALL equal b_reg[cnt], cell_bin SHALL equal borrow register, all combinational from registered state.
REQ-020 RUN: each cycle SHALL write cell_d into d[cnt], load cell_bout into borrow register, and increment cnt.
REQ-021 RUN: when cnt == WIDTH-1, SHALL additionally load cell_bout into bout and go to DONE; cnt SHALL never exceed WIDTH-1.
REQ-022 DONE: done SHALL be 1 for exactly this one cycle, then FSM SHALL return to IDLE unconditionally.
REQ-023 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-024 Latency: start accepted at edge N SHALL give done high in the cycle after edge N+WIDTH (WIDTH RUN cycles, then one DONE cycle).
REQ-025 start SHALL be ignored in RUN and DONE; operands SHALL not be resampled.
REQ-026 start asserted in IDLE on the cycle following DONE SHALL be accepted (back-to-back throughput WIDTH+2 cycles per operation).
REQ-027 d and bout SHALL hold their values from DONE until the next accepted start.
REQ-028 abort=1 in RUN SHALL return FSM to IDLE next cycle, clear d and bout to 0, and produce no done pulse; abort SHALL be ignored in IDLE and DONE.
REQ-029 abort and start both high in IDLE SHALL accept start.
REQ-030 Outside RUN, cell_a, cell_b, cell_bin SHALL be 0.
REQ-031 Counter width SHALL be max(1, ceil(log2(WIDTH))) bits; WIDTH=1 SHALL complete in one RUN cycle.

Reset
REQ-032 rst_n=0 SHALL immediately, regardless of clock, force FSM to IDLE and clear cnt, borrow, a_reg, b_reg, d, bout, busy, done to 0.
REQ-033 Reset asserted mid-RUN SHALL discard the operation without a done pulse; first start after release SHALL be accepted normally.

Verification (bench connects a correct one-bit subtractor cell to cell_* ports)
REQ-034 WIDTH=8, a=0x5A, b=0x3C, start pulse -> busy 8 cycles, done pulse, d=0x1E, bout=0.
REQ-035 WIDTH=8, a=0x00, b=0x01 -> d=0xFF, bout=1; then a=0xA5, b=0xA5 back-to-back on cycle after done -> d=0x00, bout=0.
REQ-036 start re-pulsed with a=0xFF, b=0x00 during RUN of 0x5A-0x3C -> ignored, result still 0x1E, single done pulse.
REQ-037 rst_n low at RUN cycle 4 -> all outputs 0 asynchronously, no done; next op 0x10-0x01 -> d=0x0F, bout=0.
REQ-038 abort at RUN cycle 3 -> IDLE next cycle, d=0, bout=0, no done; WIDTH=1 run a=0, b=1 -> done after one RUN cycle, d=1, bout=1.
